mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AGE_LIMIT, default 4, meaning consecutive non-fetch grants before fetch is forced to the next grant.
REQ-002 Parameter ROB_IDX_W, default 4, meaning load source tag width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; asynchronous and active-low (asserted at 0).
REQ-005 rdy  in  1  global ready; 0 freezes all state and outputs.
REQ-006 rb  in  1  rollback; cancels any pending or in-flight load.
REQ-007 st_valid, st_addr[31:0], st_data[31:0], st_len[3:0]  in  store request; st_done  out  1  completion pulse.
REQ-008 ld_valid, ld_addr[31:0], ld_len[3:0], ld_sext, ld_src[ROB_IDX_W-1:0]  in  load request; ld_done  out  1  completion pulse.
REQ-009 fc_valid, fc_addr[31:0]  in  fetch request; fc_done  out  1  completion pulse.
REQ-010 dn_valid  out  1; dn_kind  out  2 (0 fetch, 1 load, 2 store); dn_addr  out  32; dn_data  out  32; dn_len  out  4; dn_sext  out  1; dn_src  out  ROB_IDX_W: request to the byte-serial memory engine.
REQ-011 dn_done  in  1  engine completion pulse; dn_abort  out  1  one-cycle cancel of the in-flight load.

Function
REQ-012 States SHALL be IDLE, BUSY, RESP, ABORT, encoded in 2 bits.
REQ-013 While rdy=0, no register SHALL change and dn_done/rb SHALL be ignored.
REQ-014 IDLE: priority store > load > fetch; load eligible only when rb=0.
REQ-015 Aging: age counter SHALL increment on each store/load grant issued while fc_valid=1, saturate at AGE_LIMIT, and clear on fetch grant or when fc_valid=0.
REQ-016 When age = AGE_LIMIT and fc_valid=1, fetch SHALL win over store and load.
REQ-017 Grant in IDLE at edge N: dn_valid=1 and dn_* fields latched from the winner from cycle N+1; state BUSY.
REQ-018 dn_* fields SHALL stay stable while dn_valid=1; requester fields are not re-sampled.
REQ-019 BUSY with dn_done=1: dn_valid drops next cycle, the matching *_done pulses high for exactly one cycle, state RESP.
REQ-020 RESP lasts one cycle and returns to IDLE; no grant is issued in RESP, masking the still-high valid of the completed requester.
REQ-021 BUSY with granted kind=load and rb=1 (no dn_done same cycle): dn_valid drops, dn_abort=1 for one cycle, ld_done stays 0, state ABORT, then IDLE.
REQ-022 rb=1 coinciding with dn_done on a load: abort wins; ld_done SHALL NOT pulse.
REQ-023 rb during store or fetch grant SHALL have no effect.
REQ-024 dn_done outside BUSY SHALL be ignored.
REQ-025 At most one *_done SHALL be high in any cycle.

Reset
REQ-026 On rst=0, immediately: state IDLE, age 0, dn_valid 0, dn_abort 0, all *_done 0, dn_kind 0, dn_addr/dn_data 0, dn_len 0, dn_sext 0, dn_src 0.
REQ-027 Reset mid-transaction SHALL drop dn_valid without a done or abort pulse; the first grant follows one full cycle after rst deasserts.

Structure
REQ-028 Kind codes, state encodings, and the 32-bit address/word widths SHALL live in the shared utils package; ROB index width SHALL come from the existing ROB index typedef.
REQ-029 One sub-module, mem_arb_pick, SHALL be natural: combinational winner select from valids, rb, and age.

Verification
REQ-030 st_valid, ld_valid, fc_valid all 1 in IDLE -> dn_kind=2, st_addr=0x100, st_len=3 on dn_* next cycle; fc waits.
REQ-031 dn_done pulse at cycle 10 during store -> st_done=1 at cycle 11 only, no grant at cycle 11, grant resumes at cycle 12.
REQ-032 Loads continuously valid, fetch valid, AGE_LIMIT=4 -> 4 load grants, then fetch at 0x2000 granted fifth.
REQ-033 Load in BUSY, rb=1 at cycle 5 -> dn_abort=1 at cycle 6, dn_valid=0, ld_done never pulses; fetch granted after ABORT.
REQ-034 rdy=0 for 3 cycles with dn_done=1 mid-stall -> no state change, no done pulse; completion occurs on a dn_done after rdy=1.
REQ-035 rst=0 asynchronously during BUSY -> dn_valid=0 before the next edge, all done outputs 0, age=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared kinds, state encodings and word/tag types for the memory request arbiter.
package mem_arbiter_pkg;

   localparam int ADDR_W        = 32;
   localparam int WORD_W        = 32;
   localparam int ROB_IDX_W_DEF = 4;

   typedef logic [ADDR_W-1:0]        addr_t;
   typedef logic [WORD_W-1:0]        word_t;
   typedef logic [ROB_IDX_W_DEF-1:0] rob_idx_t;

   typedef enum logic [1:0] {
      KIND_FETCH = 2'd0,
      KIND_LOAD  = 2'd1,
      KIND_STORE = 2'd2
   } kind_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_RESP  = 2'd2,
      ST_ABORT = 2'd3
   } state_e;

   // Instruction fetches always move one full word through the byte engine.
   localparam logic [3:0] FETCH_LEN = 4'd4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: store > load > fetch, with a starved fetch jumping the queue.
module mem_arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic  st_valid,
   input  logic  ld_valid,
   input  logic  fc_valid,
   input  logic  rb,
   input  logic  age_full,
   output logic  grant,
   output kind_e kind
);

   always_comb begin
      grant = 1'b1;
      kind  = KIND_FETCH;
      if (fc_valid && age_full) begin
         kind = KIND_FETCH;
      end else if (st_valid) begin
         kind = KIND_STORE;
      end else if (ld_valid && !rb) begin
         kind = KIND_LOAD;
      end else if (fc_valid) begin
         kind = KIND_FETCH;
      end else begin
         grant = 1'b0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates store/load/fetch requests onto a single byte-serial memory engine.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for a request; grants the picked winner
//   ST_BUSY  | request presented on dn_*, waiting for dn_done or rollback
//   ST_RESP  | one-cycle completion slot; *_done pulses, no new grant
//   ST_ABORT | one-cycle cancel of an in-flight load; dn_abort pulses
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AGE_LIMIT = 4,
   parameter int ROB_IDX_W = $bits(rob_idx_t)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 rb,
   input  logic                 st_valid,
   input  logic [ADDR_W-1:0]    st_addr,
   input  logic [WORD_W-1:0]    st_data,
   input  logic [3:0]           st_len,
   output logic                 st_done,
   input  logic                 ld_valid,
   input  logic [ADDR_W-1:0]    ld_addr,
   input  logic [3:0]           ld_len,
   input  logic                 ld_sext,
   input  logic [ROB_IDX_W-1:0] ld_src,
   output logic                 ld_done,
   input  logic                 fc_valid,
   input  logic [ADDR_W-1:0]    fc_addr,
   output logic                 fc_done,
   output logic                 dn_valid,
   output logic [1:0]           dn_kind,
   output logic [ADDR_W-1:0]    dn_addr,
   output logic [WORD_W-1:0]    dn_data,
   output logic [3:0]           dn_len,
   output logic                 dn_sext,
   output logic [ROB_IDX_W-1:0] dn_src,
   input  logic                 dn_done,
   output logic                 dn_abort
);

   localparam int AGE_W = $clog2(AGE_LIMIT + 1);

   state_e           state;
   logic [AGE_W-1:0] age;
   logic             arm;
   logic             age_full;
   logic             pick_grant;
   kind_e            pick_kind;

   assign age_full = (age == AGE_W'(AGE_LIMIT));

   mem_arb_pick u_pick (
      .st_valid (st_valid),
      .ld_valid (ld_valid),
      .fc_valid (fc_valid),
      .rb       (rb),
      .age_full (age_full),
      .grant    (pick_grant),
      .kind     (pick_kind)
   );

   // arm holds off the first grant until a full cycle has passed after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         age      <= '0;
         arm      <= 1'b0;
         dn_valid <= 1'b0;
         dn_abort <= 1'b0;
         st_done  <= 1'b0;
         ld_done  <= 1'b0;
         fc_done  <= 1'b0;
         dn_kind  <= 2'd0;
         dn_addr  <= '0;
         dn_data  <= '0;
         dn_len   <= 4'd0;
         dn_sext  <= 1'b0;
         dn_src   <= '0;
      end else if (rdy) begin
         arm      <= 1'b1;
         dn_abort <= 1'b0;
         st_done  <= 1'b0;
         ld_done  <= 1'b0;
         fc_done  <= 1'b0;
         if (!fc_valid) begin
            age <= '0;
         end
         case (state)
            ST_IDLE: begin
               if (arm && pick_grant) begin
                  state    <= ST_BUSY;
                  dn_valid <= 1'b1;
                  dn_kind  <= pick_kind;
                  case (pick_kind)
                     KIND_STORE: begin
                        dn_addr <= st_addr;
                        dn_data <= st_data;
                        dn_len  <= st_len;
                        dn_sext <= 1'b0;
                        dn_src  <= '0;
                     end
                     KIND_LOAD: begin
                        dn_addr <= ld_addr;
                        dn_data <= '0;
                        dn_len  <= ld_len;
                        dn_sext <= ld_sext;
                        dn_src  <= ld_src;
                     end
                     default: begin
                        dn_addr <= fc_addr;
                        dn_data <= '0;
                        dn_len  <= FETCH_LEN;
                        dn_sext <= 1'b0;
                        dn_src  <= '0;
                     end
                  endcase
                  if (pick_kind == KIND_FETCH) begin
                     age <= '0;
                  end else if (fc_valid && !age_full) begin
                     age <= age + AGE_W'(1);
                  end
               end
            end
            ST_BUSY: begin
               // Rollback beats a same-cycle completion so a squashed load never reports done.
               if (dn_kind == KIND_LOAD && rb) begin
                  state    <= ST_ABORT;
                  dn_valid <= 1'b0;
                  dn_abort <= 1'b1;
               end else if (dn_done) begin
                  state    <= ST_RESP;
                  dn_valid <= 1'b0;
                  st_done  <= (dn_kind == KIND_STORE);
                  ld_done  <= (dn_kind == KIND_LOAD);
                  fc_done  <= (dn_kind == KIND_FETCH);
               end
            end
            ST_RESP:  state <= ST_IDLE;
            ST_ABORT: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: priority, aging, rollback, stall and reset behaviour.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        rb;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [3:0]  st_len;
   logic        st_done;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic [3:0]  ld_len;
   logic        ld_sext;
   logic [3:0]  ld_src;
   logic        ld_done;
   logic        fc_valid;
   logic [31:0] fc_addr;
   logic        fc_done;
   logic        dn_valid;
   logic [1:0]  dn_kind;
   logic [31:0] dn_addr;
   logic [31:0] dn_data;
   logic [3:0]  dn_len;
   logic        dn_sext;
   logic [3:0]  dn_src;
   logic        dn_done;
   logic        dn_abort;

   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter #(.AGE_LIMIT(4), .ROB_IDX_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .rb       (rb),
      .st_valid (st_valid),
      .st_addr  (st_addr),
      .st_data  (st_data),
      .st_len   (st_len),
      .st_done  (st_done),
      .ld_valid (ld_valid),
      .ld_addr  (ld_addr),
      .ld_len   (ld_len),
      .ld_sext  (ld_sext),
      .ld_src   (ld_src),
      .ld_done  (ld_done),
      .fc_valid (fc_valid),
      .fc_addr  (fc_addr),
      .fc_done  (fc_done),
      .dn_valid (dn_valid),
      .dn_kind  (dn_kind),
      .dn_addr  (dn_addr),
      .dn_data  (dn_data),
      .dn_len   (dn_len),
      .dn_sext  (dn_sext),
      .dn_src   (dn_src),
      .dn_done  (dn_done),
      .dn_abort (dn_abort)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse dn_done for one cycle, check the matching done pulse, then step RESP back to IDLE.
   task automatic finish_txn(input string tag, input logic [1:0] k);
      dn_done = 1'b1;
      tick();
      dn_done = 1'b0;
      check_val({tag, "_vld_drop"}, 32'(dn_valid), 32'd0);
      check_val({tag, "_st_done"}, 32'(st_done), 32'(k == 2'd2));
      check_val({tag, "_ld_done"}, 32'(ld_done), 32'(k == 2'd1));
      check_val({tag, "_fc_done"}, 32'(fc_done), 32'(k == 2'd0));
      tick();
      check_val({tag, "_done_1cyc"}, 32'({st_done, ld_done, fc_done}), 32'd0);
      check_val({tag, "_resp_nogrant"}, 32'(dn_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; rb = 1'b0; dn_done = 1'b0;
      st_valid = 1'b0; st_addr = '0; st_data = '0; st_len = '0;
      ld_valid = 1'b0; ld_addr = '0; ld_len = '0; ld_sext = 1'b0; ld_src = '0;
      fc_valid = 1'b0; fc_addr = '0;
      @(posedge clk); @(posedge clk); #1;

      check_val("rst_dn_valid", 32'(dn_valid), 32'd0);
      check_val("rst_dn_kind", 32'(dn_kind), 32'd0);
      check_val("rst_dn_addr", dn_addr, 32'd0);
      check_val("rst_dones", 32'({st_done, ld_done, fc_done, dn_abort}), 32'd0);

      // All three requesting: store wins
      st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hdead_beef; st_len = 4'd3;
      ld_valid = 1'b1; ld_addr = 32'h300; ld_len = 4'd2; ld_sext = 1'b1; ld_src = 4'd5;
      fc_valid = 1'b1; fc_addr = 32'h2000;
      #3 rst = 1'b1;
      tick();
      check_val("arm_gap", 32'(dn_valid), 32'd0);
      tick();
      check_val("st_grant_vld", 32'(dn_valid), 32'd1);
      check_val("st_grant_kind", 32'(dn_kind), 32'd2);
      check_val("st_grant_addr", dn_addr, 32'h100);
      check_val("st_grant_len", 32'(dn_len), 32'd3);
      check_val("st_grant_data", dn_data, 32'hdead_beef);

      st_addr = 32'h104; st_len = 4'd1;
      tick();
      check_val("stable_addr", dn_addr, 32'h100);
      check_val("stable_len", 32'(dn_len), 32'd3);
      finish_txn("st", 2'd2);

      // Clear age, then a load with no pending fetch
      st_valid = 1'b0; fc_valid = 1'b0;
      tick();
      check_val("ld_kind", 32'(dn_kind), 32'd1);
      check_val("ld_addr", dn_addr, 32'h300);
      check_val("ld_src", 32'(dn_src), 32'd5);
      check_val("ld_sext", 32'(dn_sext), 32'd1);
      check_val("ld_len", 32'(dn_len), 32'd2);
      fc_valid = 1'b1;
      finish_txn("ld0", 2'd1);

      // Four loads with fetch pending, then fetch is forced
      for (int i = 0; i < 4; i++) begin
         tick();
         check_val($sformatf("age_ld%0d_kind", i), 32'(dn_kind), 32'd1);
         finish_txn($sformatf("age_ld%0d", i), 2'd1);
      end
      tick();
      check_val("age_fc_kind", 32'(dn_kind), 32'd0);
      check_val("age_fc_addr", dn_addr, 32'h2000);
      check_val("age_fc_len", 32'(dn_len), 32'd4);
      check_val("age_cleared", 32'(dut.age), 32'd0);

      // Rollback during a fetch is ignored
      rb = 1'b1;
      tick();
      rb = 1'b0;
      check_val("rb_fc_vld", 32'(dn_valid), 32'd1);
      check_val("rb_fc_abort", 32'(dn_abort), 32'd0);
      finish_txn("fc", 2'd0);

      // Load aborted by rollback, fetch follows
      tick();
      check_val("ab_ld_kind", 32'(dn_kind), 32'd1);
      rb = 1'b1;
      tick();
      rb = 1'b0; ld_valid = 1'b0;
      check_val("ab_abort", 32'(dn_abort), 32'd1);
      check_val("ab_vld", 32'(dn_valid), 32'd0);
      check_val("ab_ld_done", 32'(ld_done), 32'd0);
      tick();
      check_val("ab_abort_1cyc", 32'(dn_abort), 32'd0);
      check_val("ab_ld_done2", 32'(ld_done), 32'd0);
      tick();
      check_val("ab_fc_kind", 32'(dn_kind), 32'd0);
      check_val("ab_fc_vld", 32'(dn_valid), 32'd1);
      finish_txn("ab_fc", 2'd0);
      fc_valid = 1'b0;

      // Rollback coinciding with dn_done on a load: abort wins
      ld_valid = 1'b1;
      tick();
      check_val("co_ld_kind", 32'(dn_kind), 32'd1);
      rb = 1'b1; dn_done = 1'b1;
      tick();
      rb = 1'b0; dn_done = 1'b0;
      check_val("co_abort", 32'(dn_abort), 32'd1);
      check_val("co_ld_done", 32'(ld_done), 32'd0);
      tick();
      check_val("co_ld_done2", 32'(ld_done), 32'd0);
      tick();
      check_val("co_regrant", 32'(dn_valid), 32'd1);

      // Stall with dn_done held: nothing moves
      rdy = 1'b0; dn_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val($sformatf("stall%0d_vld", i), 32'(dn_valid), 32'd1);
         check_val($sformatf("stall%0d_done", i), 32'(ld_done), 32'd0);
      end
      rdy = 1'b1; dn_done = 1'b0;
      tick();
      check_val("post_stall_vld", 32'(dn_valid), 32'd1);
      ld_valid = 1'b0;
      finish_txn("stall_ld", 2'd1);

      // dn_done while idle is ignored
      dn_done = 1'b1;
      tick();
      dn_done = 1'b0;
      check_val("idle_done", 32'({st_done, ld_done, fc_done}), 32'd0);
      check_val("idle_vld", 32'(dn_valid), 32'd0);

      // Asynchronous reset mid-transaction
      st_valid = 1'b1; fc_valid = 1'b1;
      tick();
      check_val("pre_rst_vld", 32'(dn_valid), 32'd1);
      #3 rst = 1'b0;
      #1;
      check_val("arst_vld", 32'(dn_valid), 32'd0);
      check_val("arst_dones", 32'({st_done, ld_done, fc_done, dn_abort}), 32'd0);
      check_val("arst_age", 32'(dut.age), 32'd0);
      check_val("arst_kind", 32'(dn_kind), 32'd0);
      #3 rst = 1'b1;
      tick();
      check_val("arst_gap", 32'(dn_valid), 32'd0);
      tick();
      check_val("arst_regrant", 32'(dn_kind), 32'd2);
      check_val("arst_regrant_vld", 32'(dn_valid), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
